// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
// Instruction fetch controller: fetches a word, holds it for execution, forms the next PC,
// and traps on a misaligned target or a fetch that never completes.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pcmux,
    input  logic [31:0] immb,
    input  logic [31:0] immj,
    input  logic [31:0] jt,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        TRAP  = 2'b11
    } state_t;

    state_t            state_reg;
    logic [31:0]       pc_reg;
    logic [31:0]       instr_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic              req_reg;
    logic              valid_reg;
    logic              fault_reg;
    logic [1:0]        cause_reg;
    logic [31:0]       pc_next;

    always_comb begin
        pc_next = pc_reg + 32'd4;
        case (pcmux)
            2'b00: pc_next = pc_reg + 32'd4;
            2'b01: pc_next = pc_reg + immb;
            2'b10: pc_next = pc_reg + immj;
            2'b11: pc_next = jt;
        endcase
    end

    // Outputs are registered alongside the state so each one is a flop, never a decode of inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0;
            wait_reg  <= '0;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
            fault_reg <= 1'b0;
            cause_reg <= CAUSE_NONE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= FETCH;
                    req_reg   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        wait_reg  <= '0;
                        state_reg <= EXEC;
                        req_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                    end else if (wait_reg == WAIT_LAST) begin
                        wait_reg  <= wait_reg + 1'b1;
                        state_reg <= TRAP;
                        req_reg   <= 1'b0;
                        fault_reg <= 1'b1;
                        cause_reg <= CAUSE_TIMEOUT;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                EXEC: begin
                    // A stalled cycle neither advances nor checks alignment.
                    if (!stall) begin
                        valid_reg <= 1'b0;
                        if (pc_next[1:0] != 2'b00) begin
                            state_reg <= TRAP;
                            fault_reg <= 1'b1;
                            cause_reg <= CAUSE_MISALIGN;
                        end else begin
                            pc_reg    <= pc_next;
                            state_reg <= FETCH;
                            req_reg   <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    state_reg <= TRAP;
                end
            endcase
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign fault       = fault_reg;
    assign fault_cause = cause_reg;

endmodule
